spi_readback_tx: RTL and testbench

- SPI slave transmit stage. Runs beside the existing MOSI capture shift register, on the same SCLK/SS/MOSI pins.
- Decodes the command byte of each 16-bit frame and presents the read address to the register file.
- For read frames, shifts the returned byte out on MISO, MSB first, during the second byte of the same frame.
- Raises a flag when a frame runs longer than its defined length.

---
 rtl/spi_readback_tx_pkg.sv | 16 +
 rtl/spi_readback_tx_if.sv | 26 ++
 rtl/spi_tx_shift.sv | 34 +++
 rtl/spi_readback_tx.sv | 96 +++++++++
 tb/tb_spi_readback_tx.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/spi_readback_tx_pkg.sv
// Shared constants and state encoding for the SPI readback transmit stage.
package spi_readback_tx_pkg;
  localparam int unsigned SPI_ADDR_W     = 7;
  localparam int unsigned SPI_DATA_W     = 8;
  localparam int unsigned SPI_FRAME_BITS = 16;
  localparam int unsigned SPI_CNT_W      = 5;
  localparam logic        SPI_RW_READ    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    DONE,
    OVER
  } spi_state_e;
endpackage

// File: rtl/spi_readback_tx_if.sv
// SPI pin and register-file readback signals for spi_readback_tx.
interface spi_readback_tx_if
  import spi_readback_tx_pkg::*;
#(
  parameter int unsigned ADDR_W = SPI_ADDR_W,
  parameter int unsigned DATA_W = SPI_DATA_W
) ();
  logic              SS;
  logic              MOSI;
  logic [DATA_W-1:0] RD_DATA;
  logic [ADDR_W-1:0] RD_ADDR;
  logic              RD_TOG;
  logic              MISO;
  logic              MISO_OE;
  logic              OVERRUN;

  modport slave (
    input  SS, MOSI, RD_DATA,
    output RD_ADDR, RD_TOG, MISO, MISO_OE, OVERRUN
  );

  modport master (
    output SS, MOSI, RD_DATA,
    input  RD_ADDR, RD_TOG, MISO, MISO_OE, OVERRUN
  );
endinterface

// File: rtl/spi_tx_shift.sv
// Falling-edge MISO shifter: loads readback data, shifts MSB first, then releases the pad.
module spi_tx_shift
  import spi_readback_tx_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
) (
  input  logic              SCLK,
  input  logic              clr_n,
  input  logic              load,
  input  logic              shift,
  input  logic              stop,
  input  logic [DATA_W-1:0] rd_data,
  output logic              MISO,
  output logic              MISO_OE
);
  logic [DATA_W-1:0] tx_sr;

  always_ff @(negedge SCLK or negedge clr_n) begin
    if (!clr_n) begin
      tx_sr   <= '0;
      MISO_OE <= 1'b0;
    end else if (load) begin
      tx_sr   <= rd_data;
      MISO_OE <= 1'b1;
    end else if (shift) begin
      tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
    end else if (stop) begin
      tx_sr   <= '0;
      MISO_OE <= 1'b0;
    end
  end

  assign MISO = tx_sr[DATA_W-1];
endmodule

// File: rtl/spi_readback_tx.sv
// SPI slave transmit stage: decodes the command byte and shifts readback data out on MISO.
module spi_readback_tx
  import spi_readback_tx_pkg::*;
#(
  parameter int unsigned ADDR_W = SPI_ADDR_W,
  parameter int unsigned DATA_W = SPI_DATA_W
) (
  input  logic                 SCLK,
  input  logic                 RST,
  spi_readback_tx_if.slave     bus
);
  localparam int unsigned FRAME_BITS = 1 + ADDR_W + DATA_W;
  localparam logic [SPI_CNT_W-1:0] CNT_CMD_LAST  = SPI_CNT_W'(ADDR_W);
  localparam logic [SPI_CNT_W-1:0] CNT_CMD_END   = SPI_CNT_W'(ADDR_W + 1);
  localparam logic [SPI_CNT_W-1:0] CNT_DATA_LAST = SPI_CNT_W'(FRAME_BITS - 1);
  localparam logic [SPI_CNT_W-1:0] CNT_FRAME_END = SPI_CNT_W'(FRAME_BITS);

  spi_state_e          state, state_nxt;
  logic [SPI_CNT_W-1:0] bit_cnt;
  logic [ADDR_W-1:0]    cmd_sr;
  logic [ADDR_W:0]      cmd_word;
  logic                 rd_flag;
  logic                 frame_clr_n;
  logic                 cmd_last, cmd_is_read, ovr_set;
  logic                 tx_load, tx_shift, tx_stop;

  // SS high clears the frame logic; RD_ADDR/RD_TOG survive it and only see RST.
  assign frame_clr_n = RST & ~bus.SS;
  assign cmd_word    = {cmd_sr, bus.MOSI};

  always_ff @(posedge SCLK or negedge frame_clr_n) begin
    if (!frame_clr_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      rd_flag     <= 1'b0;
      bus.OVERRUN <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bit_cnt != '1)
        bit_cnt <= bit_cnt + 1'b1;
      if (state == IDLE || state == CMD)
        cmd_sr <= cmd_word[ADDR_W-1:0];
      if (cmd_last && cmd_is_read)
        rd_flag <= 1'b1;
      if (ovr_set)
        bus.OVERRUN <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = CMD;
      CMD:     if (bit_cnt == CNT_CMD_LAST) state_nxt = DATA;
      DATA:    if (bit_cnt == CNT_DATA_LAST) state_nxt = DONE;
      DONE:    state_nxt = OVER;
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  // Falling-edge strobes key off the count left by the preceding rising edge.
  always_comb begin
    cmd_last    = (state == CMD) && (bit_cnt == CNT_CMD_LAST);
    cmd_is_read = (cmd_word[ADDR_W] == SPI_RW_READ);
    ovr_set     = (state == DONE);
    tx_load     = rd_flag && (bit_cnt == CNT_CMD_END);
    tx_shift    = rd_flag && (bit_cnt > CNT_CMD_END) && (bit_cnt < CNT_FRAME_END);
    tx_stop     = rd_flag && (bit_cnt == CNT_FRAME_END);
  end

  always_ff @(posedge SCLK or negedge RST) begin
    if (!RST) begin
      bus.RD_ADDR <= '0;
      bus.RD_TOG  <= 1'b0;
    end else if (cmd_last) begin
      bus.RD_ADDR <= cmd_word[ADDR_W-1:0];
      if (cmd_is_read)
        bus.RD_TOG <= ~bus.RD_TOG;
    end
  end

  spi_tx_shift #(
    .DATA_W(DATA_W)
  ) u_tx_shift (
    .SCLK    (SCLK),
    .clr_n   (frame_clr_n),
    .load    (tx_load),
    .shift   (tx_shift),
    .stop    (tx_stop),
    .rd_data (bus.RD_DATA),
    .MISO    (bus.MISO),
    .MISO_OE (bus.MISO_OE)
  );
endmodule

// File: tb/tb_spi_readback_tx.sv
// Directed testbench for spi_readback_tx with a small register-file model on RD_DATA.
module tb_spi_readback_tx;
  import spi_readback_tx_pkg::*;

  logic SCLK;
  logic RST;
  int   checks;
  int   errors;
  int   n;
  logic exp_tog;
  logic miso_log [0:40];
  logic oe_log   [0:40];
  logic ovr_log  [0:40];

  spi_readback_tx_if #(.ADDR_W(SPI_ADDR_W), .DATA_W(SPI_DATA_W)) bus ();

  spi_readback_tx #(
    .ADDR_W(SPI_ADDR_W),
    .DATA_W(SPI_DATA_W)
  ) dut (
    .SCLK (SCLK),
    .RST  (RST),
    .bus  (bus)
  );

  function automatic logic [7:0] rf(input logic [6:0] a);
    case (a)
      7'h05:   return 8'hA5;
      7'h01:   return 8'h3C;
      7'h7F:   return 8'hC3;
      default: return {1'b0, a} ^ 8'h5A;
    endcase
  endfunction

  always_comb bus.RD_DATA = rf(bus.RD_ADDR);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clk_edge(input logic b);
    bus.MOSI = b;
    #5 SCLK = 1'b1;
    #5 ovr_log[n] = bus.OVERRUN;
    #5 SCLK = 1'b0;
    #5 miso_log[n] = bus.MISO;
    oe_log[n] = bus.MISO_OE;
    n++;
  endtask

  task automatic send(input logic [15:0] bits, input int edges);
    bus.SS = 1'b0;
    n = 1;
    #5;
    for (int i = 0; i < edges; i++)
      clk_edge(i < 16 ? bits[15-i] : 1'b0);
  endtask

  task automatic end_frame();
    #5 bus.SS = 1'b1;
    #10;
  endtask

  function automatic logic [7:0] miso_byte();
    logic [7:0] v;
    for (int k = 8; k <= 15; k++) v[15-k] = miso_log[k];
    return v;
  endfunction

  function automatic logic [15:0] oe_vec();
    logic [15:0] v;
    for (int k = 1; k <= 16; k++) v[16-k] = oe_log[k];
    return v;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    n       = 0;
    SCLK    = 1'b0;
    RST     = 1'b0;
    bus.SS  = 1'b1;
    bus.MOSI = 1'b0;
    #20;
    check("rst_addr",  32'(bus.RD_ADDR), 0);
    check("rst_tog",   32'(bus.RD_TOG), 0);
    check("rst_miso",  32'(bus.MISO), 0);
    check("rst_oe",    32'(bus.MISO_OE), 0);
    check("rst_ovr",   32'(bus.OVERRUN), 0);
    RST = 1'b1;
    exp_tog = 1'b0;
    #10;

    // read 0x05 -> 0xA5
    send(16'h8500, 16);
    exp_tog = ~exp_tog;
    check("rd_addr",   32'(bus.RD_ADDR), 32'h05);
    check("rd_tog",    32'(bus.RD_TOG), 32'(exp_tog));
    check("rd_miso",   32'(miso_byte()), 32'hA5);
    check("rd_oe",     32'(oe_vec()), 32'h01FE);
    check("rd_ovr",    32'(bus.OVERRUN), 0);
    end_frame();
    check("rd_oe_ss",  32'(bus.MISO_OE), 0);

    // write 0x12 data 0x3C
    send(16'h123C, 16);
    check("wr_addr",   32'(bus.RD_ADDR), 32'h12);
    check("wr_tog",    32'(bus.RD_TOG), 32'(exp_tog));
    check("wr_oe",     32'(oe_vec()), 0);
    check("wr_miso",   32'(miso_byte()), 0);
    end_frame();

    // back-to-back reads 0x01, 0x7F
    send(16'h8100, 16);
    exp_tog = ~exp_tog;
    check("b2b1_tog",  32'(bus.RD_TOG), 32'(exp_tog));
    check("b2b1_miso", 32'(miso_byte()), 32'h3C);
    end_frame();
    send(16'hFF00, 16);
    exp_tog = ~exp_tog;
    check("b2b2_addr", 32'(bus.RD_ADDR), 32'h7F);
    check("b2b2_tog",  32'(bus.RD_TOG), 32'(exp_tog));
    check("b2b2_miso", 32'(miso_byte()), 32'hC3);
    end_frame();

    // overrun: 18 edges on a read frame
    send(16'h8500, 18);
    exp_tog = ~exp_tog;
    check("ovr_e16",   32'(ovr_log[16]), 0);
    check("ovr_e17",   32'(ovr_log[17]), 1);
    check("ovr_e18",   32'(ovr_log[18]), 1);
    check("ovr_oe16",  32'(oe_log[16]), 0);
    check("ovr_oe17",  32'(oe_log[17]), 0);
    check("ovr_miso",  32'(miso_byte()), 32'hA5);
    end_frame();
    check("ovr_clr",   32'(bus.OVERRUN), 0);

    // short read: SS rises after edge 11
    send(16'h8100, 11);
    exp_tog = ~exp_tog;
    check("sh_oe11",   32'(oe_log[11]), 1);
    check("sh_tog",    32'(bus.RD_TOG), 32'(exp_tog));
    bus.SS = 1'b1;
    #1;
    check("sh_oe_clr", 32'(bus.MISO_OE), 0);
    check("sh_cnt",    32'(dut.bit_cnt), 0);
    #10;
    send(16'h8500, 16);
    exp_tog = ~exp_tog;
    check("sh_nx_addr", 32'(bus.RD_ADDR), 32'h05);
    check("sh_nx_miso", 32'(miso_byte()), 32'hA5);
    check("sh_nx_oe",   32'(oe_vec()), 32'h01FE);
    end_frame();

    // RST mid-frame after edge 12
    send(16'hFF00, 12);
    check("mr_oe_pre", 32'(bus.MISO_OE), 1);
    RST = 1'b0;
    #1;
    exp_tog = 1'b0;
    check("mr_addr",   32'(bus.RD_ADDR), 0);
    check("mr_tog",    32'(bus.RD_TOG), 0);
    check("mr_miso",   32'(bus.MISO), 0);
    check("mr_oe",     32'(bus.MISO_OE), 0);
    check("mr_ovr",    32'(bus.OVERRUN), 0);
    #5 bus.SS = 1'b1;
    #5 RST = 1'b1;
    #10;
    send(16'h8100, 16);
    exp_tog = ~exp_tog;
    check("mr_nx_addr", 32'(bus.RD_ADDR), 32'h01);
    check("mr_nx_tog",  32'(bus.RD_TOG), 32'(exp_tog));
    check("mr_nx_miso", 32'(miso_byte()), 32'h3C);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
